// File: rtl/bitstream_pkg.sv
// Shared definitions for the serial configuration loader: FSM encoding,
// default frame marker and the frame checksum.
package bitstream_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

    // Widest bitfile the checksum helper supports; narrower words are zero-padded.
    localparam int MAX_BYTES = 16;
    localparam int MAX_BW    = 8 * MAX_BYTES;

    // Zero padding bytes leave the XOR unchanged, so every slot can be folded in.
    function automatic logic [7:0] checksum(input logic [MAX_BW-1:0] data);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            acc = acc ^ data[8*i +: 8];
        end
        return ~acc;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in/parallel-out shift register, new bit enters the LSB.
// Clear has priority over shift enable.
module cfg_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [W-1:0] q
);

    // NOTE: sequential state is always written with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[W-2:0], din};
        end
    end

endmodule

// File: rtl/bitstream_loader.sv
// Framed serial configuration loader: hunts for the sync marker, shifts in data
// and checksum, and updates the bitfile atomically only on a good checksum.
module bitstream_loader
    import bitstream_pkg::*;
#(
    parameter int         NUM_BYTES = 1,
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    input  logic                   cfg_bit,
    output logic                   cfg_ready,
    input  logic                   abort,
    output logic [8*NUM_BYTES-1:0] bitfile,
    output logic                   cfg_done,
    output logic                   cfg_err,
    output logic                   busy
);

    localparam int BW = 8 * NUM_BYTES;
    localparam int CW = $clog2(BW);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [7:0]      sync_q;
    logic [BW-1:0]   data_q;
    logic [7:0]      chk_q;
    logic            match_q;
    logic            accept;
    logic            chk_ok;
    logic [MAX_BW-1:0] data_pad;

    assign cfg_ready = (state_q != COMMIT);
    assign accept    = cfg_valid && cfg_ready;

    // Sync search restarts from an empty window whenever the FSM comes back to HUNT.
    cfg_shift_reg #(.W(8)) u_sync (
        .clk (clk),
        .rst (rst),
        .clr (state_q != HUNT),
        .en  (accept && (state_q == HUNT)),
        .din (cfg_bit),
        .q   (sync_q)
    );

    cfg_shift_reg #(.W(BW)) u_data (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (accept && (state_q == LOAD)),
        .din (cfg_bit),
        .q   (data_q)
    );

    cfg_shift_reg #(.W(8)) u_chk (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (accept && (state_q == CHECK)),
        .din (cfg_bit),
        .q   (chk_q)
    );

    // Compare against the checksum including the bit being accepted this cycle.
    always_comb begin
        data_pad          = '0;
        data_pad[BW-1:0]  = data_q;
        chk_ok            = (checksum(data_pad) == {chk_q[6:0], cfg_bit});
    end

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HUNT: begin
                if (accept && ({sync_q[6:0], cfg_bit} == SYNC_WORD)) state_d = LOAD;
            end
            LOAD: begin
                if (abort)                                    state_d = HUNT;
                else if (accept && (cnt_q == CW'(BW - 1)))    state_d = CHECK;
            end
            CHECK: begin
                if (abort)                                    state_d = HUNT;
                else if (accept && (cnt_q == CW'(7)))         state_d = COMMIT;
            end
            COMMIT:                                           state_d = HUNT;
            default:                                          state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            cnt_q    <= '0;
            match_q  <= 1'b0;
            bitfile  <= '0;
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy     <= (state_d != HUNT);
            cfg_done <= 1'b0;
            cfg_err  <= 1'b0;

            if (state_d != state_q) begin
                cnt_q <= '0;
            end else if (accept && ((state_q == LOAD) || (state_q == CHECK))) begin
                cnt_q <= cnt_q + 1'b1;
            end

            if (accept && (state_q == CHECK)) begin
                match_q <= chk_ok;
            end

            if (state_q == COMMIT) begin
                if (match_q) begin
                    bitfile  <= data_q;
                    cfg_done <= 1'b1;
                end else begin
                    cfg_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: one 1-byte and one 2-byte instance
// driven with hand-built frames and hand-computed expected bitfiles.
module tb_bitstream_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        v1 = 1'b0, b1 = 1'b0, a1 = 1'b0;
    logic        rdy1, done1, err1, busy1;
    logic [7:0]  bf1;

    logic        v2 = 1'b0, b2 = 1'b0, a2 = 1'b0;
    logic        rdy2, done2, err2, busy2;
    logic [15:0] bf2;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt1 = 0, err_cnt1 = 0, done_cnt2 = 0, err_cnt2 = 0;

    bitstream_loader #(.NUM_BYTES(1)) dut1 (
        .clk(clk), .rst(rst), .cfg_valid(v1), .cfg_bit(b1), .cfg_ready(rdy1),
        .abort(a1), .bitfile(bf1), .cfg_done(done1), .cfg_err(err1), .busy(busy1)
    );

    bitstream_loader #(.NUM_BYTES(2)) dut2 (
        .clk(clk), .rst(rst), .cfg_valid(v2), .cfg_bit(b2), .cfg_ready(rdy2),
        .abort(a2), .bitfile(bf2), .cfg_done(done2), .cfg_err(err2), .busy(busy2)
    );

    always @(posedge clk) begin
        if (done1) done_cnt1++;
        if (err1)  err_cnt1++;
        if (done2) done_cnt2++;
        if (err2)  err_cnt2++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input int d, input logic bv);
        int tries;
        tries = 0;
        if (d == 0) begin v1 = 1'b1; b1 = bv; end
        else        begin v2 = 1'b1; b2 = bv; end
        while (((d == 0) ? rdy1 : rdy2) !== 1'b1) begin
            idle(1);
            tries++;
            if (tries > 8) begin
                check("ready_wait", (d == 0) ? rdy1 : rdy2, 1'b1);
                break;
            end
        end
        idle(1);
        if (d == 0) v1 = 1'b0;
        else        v2 = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] val, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            if (gaps) idle($urandom_range(0, 3));
            send_bit(d, val[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(2);
        rst = 1'b0;
        check("rst_bitfile", bf1, 8'h00);
        check("rst_done", done1, 1'b0);
        check("rst_err", err1, 1'b0);
        check("rst_busy", busy1, 1'b0);
        check("rst_ready", rdy1, 1'b1);

        // 1: good frame, exact commit latency and slice decode
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'hE4, 0);
        send_byte(0, 8'h1B, 0);
        check("t1_commit_busy", busy1, 1'b1);
        check("t1_commit_ready", rdy1, 1'b0);
        check("t1_commit_bitfile", bf1, 8'h00);
        check("t1_commit_done", done1, 1'b0);
        idle(1);
        check("t1_bitfile", bf1, 8'hE4);
        check("t1_done", done1, 1'b1);
        check("t1_err", err1, 1'b0);
        check("t1_busy_after", busy1, 1'b0);
        check("t1_ready_after", rdy1, 1'b1);
        idle(1);
        check("t1_done_pulse", done1, 1'b0);
        check("t1_slice0", bf1[1:0], 2'b00);
        check("t1_slice1", bf1[3:2], 2'b01);
        check("t1_slice2", bf1[5:4], 2'b10);
        check("t1_slice3", bf1[7:6], 2'b11);
        check("t1_done_cnt", done_cnt1, 1);

        // 2: bad checksum keeps the old bitfile
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h3C, 0);
        send_byte(0, 8'h00, 0);
        idle(1);
        check("t2_err", err1, 1'b1);
        check("t2_done", done1, 1'b0);
        check("t2_bitfile", bf1, 8'hE4);
        idle(1);
        check("t2_err_pulse", err1, 1'b0);
        check("t2_done_cnt", done_cnt1, 1);
        check("t2_err_cnt", err_cnt1, 1);

        // 3: noise and valid gaps
        send_byte(0, 8'hFF, 1);
        send_byte(0, 8'hA5, 1);
        send_byte(0, 8'h0F, 1);
        send_byte(0, 8'hF0, 1);
        idle(2);
        check("t3_bitfile", bf1, 8'h0F);
        check("t3_done_cnt", done_cnt1, 2);
        check("t3_err_cnt", err_cnt1, 1);

        // 4: abort mid-LOAD, then a clean frame
        send_byte(0, 8'hA5, 0);
        for (int i = 0; i < 4; i++) send_bit(0, (i < 2) ? 1'b1 : 1'b0);
        check("t4_busy_loading", busy1, 1'b1);
        a1 = 1'b1;
        idle(1);
        a1 = 1'b0;
        check("t4_busy_abort", busy1, 1'b0);
        check("t4_bitfile_abort", bf1, 8'h0F);
        idle(2);
        check("t4_done_cnt_abort", done_cnt1, 2);
        check("t4_err_cnt_abort", err_cnt1, 1);
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h81, 0);
        send_byte(0, 8'h7E, 0);
        idle(2);
        check("t4_bitfile", bf1, 8'h81);
        check("t4_done_cnt", done_cnt1, 3);

        // abort during COMMIT is ignored
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h3C, 0);
        send_byte(0, 8'hC3, 0);
        a1 = 1'b1;
        idle(1);
        a1 = 1'b0;
        check("t4b_done", done1, 1'b1);
        check("t4b_bitfile", bf1, 8'h3C);
        idle(1);
        check("t4b_done_cnt", done_cnt1, 4);

        // 5: reset during CHECK
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h55, 0);
        for (int i = 0; i < 4; i++) send_bit(0, (i % 2 == 0) ? 1'b1 : 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("t5_bitfile", bf1, 8'h00);
        check("t5_busy", busy1, 1'b0);
        check("t5_ready", rdy1, 1'b1);
        idle(2);
        check("t5_done_cnt", done_cnt1, 4);
        check("t5_err_cnt", err_cnt1, 1);
        send_byte(0, 8'hA5, 0);
        send_byte(0, 8'h55, 0);
        send_byte(0, 8'hAA, 0);
        idle(2);
        check("t5_reload", bf1, 8'h55);
        check("t5_done_cnt2", done_cnt1, 5);

        // 6: two-byte frame, then abort on the final checksum bit
        send_byte(1, 8'hA5, 0);
        send_byte(1, 8'h12, 0);
        send_byte(1, 8'h34, 0);
        send_byte(1, 8'hD9, 0);
        idle(1);
        check("t6_done", done2, 1'b1);
        check("t6_bitfile", bf2, 16'h1234);
        idle(1);
        check("t6_done_cnt", done_cnt2, 1);
        send_byte(1, 8'hA5, 0);
        send_byte(1, 8'hAB, 0);
        send_byte(1, 8'hCD, 0);
        for (int i = 7; i >= 1; i--) send_bit(1, 8'h99 >> i);
        a2 = 1'b1;
        send_bit(1, 1'b1);
        a2 = 1'b0;
        check("t6_abort_busy", busy2, 1'b0);
        check("t6_abort_ready", rdy2, 1'b1);
        idle(2);
        check("t6_abort_bitfile", bf2, 16'h1234);
        check("t6_abort_done_cnt", done_cnt2, 1);
        check("t6_abort_err_cnt", err_cnt2, 0);
        send_byte(1, 8'hA5, 0);
        send_byte(1, 8'hAB, 0);
        send_byte(1, 8'hCD, 0);
        send_byte(1, 8'h99, 0);
        idle(2);
        check("t6_reload", bf2, 16'hABCD);
        check("t6_done_cnt2", done_cnt2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bitstream_loader.md
Name: bitstream_loader

Overview:
- Serial configuration loader. It receives a framed bit-serial configuration stream, checks it, and atomically drives the parallel bitfile word that the fabric controller slices into 2-bit control signals.
- It is the writer side of the bitfile interface and sits between the external configuration pin pair and the controller's bitfile input.
- A new bitfile takes effect only after a good checksum. A bad or aborted frame leaves the previous configuration untouched.

Parameters:
- NUM_BYTES, 1, number of configuration data bytes per frame. Bitfile width BW = 8*NUM_BYTES is a derived localparam.
- SYNC_WORD, 8'hA5, frame start marker searched for on the serial stream.

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial configuration bit, MSB-first within each byte.
- cfg_ready  output  1  loader accepts a bit this cycle. A bit transfers when cfg_valid && cfg_ready.
- abort  input  1  discard the frame in progress.
- bitfile  output  BW  committed configuration word, feeds the controller.
- cfg_done  output  1  one-cycle pulse, new bitfile committed.
- cfg_err  output  1  one-cycle pulse, checksum mismatch.
- busy  output  1  high in LOAD, CHECK and COMMIT.

Behaviour:
- Reset (synchronous, active-high, on clk): clears all state and outputs.
  - Reset values: state=HUNT, bitfile=0, cfg_done=0, cfg_err=0, busy=0, shift registers=0, counters=0.
  - cfg_ready=1 after reset.
  - Reset mid-frame discards the partial frame and also zeroes bitfile.
- The FSM has states HUNT, LOAD, CHECK, COMMIT.
- HUNT:
  - Each accepted bit shifts into an 8-bit sync register (new bit enters the LSB).
  - When the register equals SYNC_WORD after a shift, go to LOAD and clear the bit counter.
  - Overlapping sync patterns are honoured. The search is purely sliding.
- LOAD:
  - Shift BW accepted bits into the data shift register. Byte order is MSB byte first, bit order MSB-first.
  - The counter runs 0..BW-1. The accept at count BW-1 moves the FSM to CHECK with the counter cleared.
- CHECK:
  - Shift 8 accepted bits into the checksum register.
  - The required checksum is the bitwise NOT of the XOR of all NUM_BYTES data bytes.
  - The 8th accepted bit moves the FSM to COMMIT. The comparison uses the complete checksum including that bit, registered into a match flag.
- COMMIT (exactly one cycle):
  - cfg_ready=0 in this state.
  - On match: bitfile <= data register, cfg_done pulses high for the cycle after COMMIT.
  - On mismatch: bitfile unchanged, cfg_err pulses high for the cycle after COMMIT.
  - Next state is always HUNT, with the sync register cleared.
- Latency: the last checksum bit is accepted at edge N. COMMIT holds during cycle N..N+1. bitfile and cfg_done/cfg_err change at edge N+1.
- cfg_ready=1 in HUNT, LOAD and CHECK. Cycles with cfg_valid=0 stall the counters with no timeout.
- abort:
  - In LOAD or CHECK, abort returns to HUNT at the next edge with no pulse, and bitfile is unchanged.
  - abort wins over a simultaneous final-bit accept.
  - abort is ignored in HUNT and COMMIT, so a commit in flight completes.
- Simultaneous rst and abort: rst wins.
- busy is registered from state and is high in LOAD, CHECK and COMMIT.
- bitfile is only ever written in COMMIT-on-match or by reset. It never shows partial data.

Decomposition:
- Shared package (bitstream_pkg):
  - FSM state encoding (HUNT, LOAD, CHECK, COMMIT).
  - SYNC_WORD default.
  - Checksum function (NOT of byte-wise XOR over BW bits).
- One natural sub-module: cfg_shift_reg. It is a parameterised serial-in/parallel-out shift register with enable and synchronous clear. It is instanced for the sync, data and checksum registers.

Test Plan:
1. Reset, then send A5, E4, 1B (NUM_BYTES=1) with cfg_valid held high.
   - Required: bitfile=8'hE4 one edge after COMMIT, cfg_done single pulse, cfg_err=0.
   - Downstream slices decode as [1:0]=00, [3:2]=01, [5:4]=10, [7:6]=11.
2. After test 1, send A5, 3C, 00 (bad checksum; the good value is C3).
   - Required: cfg_err one pulse, cfg_done=0, bitfile stays 8'hE4.
3. Send 0xFF noise, then A5, 0F, F0, with random cfg_valid gaps of 0-3 cycles.
   - Required: sync found despite noise and stalls, bitfile=8'h0F, one cfg_done.
4. Send A5 plus 4 data bits, then assert abort. Next, send a full good frame A5, 81, 7E.
   - Required: no pulse on abort, busy drops the next cycle, then bitfile=8'h81.
5. Assert rst during CHECK of a good frame A5, 55, AA.
   - Required: bitfile=0, busy=0, no pulses, and the next good frame loads normally.
6. With NUM_BYTES=2, send A5, 12, 34, D9.
   - Required: bitfile=16'h1234 and cfg_done.
   - Also assert abort on the exact cycle the final checksum bit is accepted; the frame must be discarded.
